// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the fetch-to-decode queue.
package fetch_queue_pkg;

  localparam int FQ_AW    = 16;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [FQ_AW-1:0] pc;
    logic [FQ_AW-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Queue storage: one synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents are never reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with flush; inReady depends on registered occupancy only.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   inValid,
  input  logic [AW-1:0]          inPc,
  input  logic [AW-1:0]          inInstr,
  output logic                   inReady,
  output logic                   outValid,
  output logic [AW-1:0]          outPc,
  output logic [AW-1:0]          outInstr,
  input  logic                   outReady,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [2*AW-1:0] rd_data;
  logic            enq;
  logic            deq;

  // A slot freed by this cycle's dequeue is only offered next cycle.
  assign inReady  = (count < CW'(DEPTH));
  assign outValid = (count != '0);

  assign enq = inValid && inReady && !flush;
  assign deq = outValid && outReady && !flush;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (2 * AW)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata ({inPc, inInstr}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign outPc    = outValid ? rd_data[2*AW-1:AW] : '0;
  assign outInstr = outValid ? rd_data[AW-1:0]    : '0;

endmodule
